ps2_dir_decoder: RTL and testbench

//  Turns the PS/2 receiver's scan-code stream into maze movement commands.

---
 rtl/ps2_dir_decoder_pkg.sv | 72 +++++++
 rtl/ps2_dir_decoder_key_repeat_timer.sv | 55 +++++
 rtl/ps2_dir_decoder.sv | 111 +++++++++++
 tb/tb_ps2_dir_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_dir_decoder_pkg.sv
// Shared definitions for the PS/2 direction decoder: direction encodings,
// scan codes, repeat-timer states and key lookup helpers.
package ps2_dir_decoder_pkg;

   localparam logic [3:0] PA_DN    = 4'b0001;
   localparam logic [3:0] PA_RIGHT = 4'b0010;
   localparam logic [3:0] PA_UP    = 4'b0100;
   localparam logic [3:0] PA_LEFT  = 4'b1000;
   localparam logic [3:0] STOP     = 4'b0000;

   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_R     = 8'h2D;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_t;

   // Returns {hit, index}; letters only match plain codes, arrows only E0 codes.
   function automatic logic [2:0] key_lookup(input logic [7:0] code, input logic ext);
      logic [2:0] res;
      res = 3'b000;
      if (!ext) begin
         case (code)
            SC_S:    res = 3'b100;
            SC_D:    res = 3'b101;
            SC_W:    res = 3'b110;
            SC_A:    res = 3'b111;
            default: res = 3'b000;
         endcase
      end else begin
         case (code)
            SC_DOWN:  res = 3'b100;
            SC_RIGHT: res = 3'b101;
            SC_UP:    res = 3'b110;
            SC_LEFT:  res = 3'b111;
            default:  res = 3'b000;
         endcase
      end
      return res;
   endfunction

   function automatic logic [1:0] lowest_index(input logic [3:0] mask);
      logic [1:0] idx;
      idx = 2'd0;
      if (mask[0])      idx = 2'd0;
      else if (mask[1]) idx = 2'd1;
      else if (mask[2]) idx = 2'd2;
      else if (mask[3]) idx = 2'd3;
      return idx;
   endfunction

   function automatic logic [3:0] dir_of(input logic [1:0] idx);
      logic [3:0] d;
      case (idx)
         2'd0:    d = PA_DN;
         2'd1:    d = PA_RIGHT;
         2'd2:    d = PA_UP;
         default: d = PA_LEFT;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/ps2_dir_decoder_key_repeat_timer.sv
// Keyboard-style auto-repeat: immediate step on (re)trigger, first repeat
// after DELAY_CYC cycles, then one step every REPEAT_CYC cycles.
module ps2_dir_decoder_key_repeat_timer
   import ps2_dir_decoder_pkg::*;
#(
   parameter int unsigned DELAY_CYC  = 25_000_000,
   parameter int unsigned REPEAT_CYC = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart_dly,
   input  logic clear,
   input  logic pulse_en,
   output logic tick
);

   rpt_state_t  state;
   logic [31:0] cnt;

   // clear beats restart_dly, and both beat a coinciding expiry so a key
   // event never produces a second step in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 32'd0;
         tick  <= 1'b0;
      end else if (clear) begin
         state <= IDLE;
         cnt   <= 32'd0;
         tick  <= 1'b0;
      end else if (restart_dly) begin
         state <= DELAY;
         cnt   <= DELAY_CYC - 32'd1;
         tick  <= pulse_en;
      end else begin
         tick <= 1'b0;
         case (state)
            DELAY, REPEAT: begin
               if (cnt == 32'd0) begin
                  state <= REPEAT;
                  cnt   <= REPEAT_CYC - 32'd1;
                  tick  <= pulse_en;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 32'd0;
            end
         endcase
      end
   end

endmodule

// File: rtl/ps2_dir_decoder.sv
// Converts PS/2 receiver words into a held one-hot maze direction, auto-repeating
// step pulses and a restart pulse on 'R'.
module ps2_dir_decoder
   import ps2_dir_decoder_pkg::*;
#(
   parameter int unsigned DELAY_CYC  = 25_000_000,
   parameter int unsigned REPEAT_CYC = 10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] ps2_data,
   input  logic       ps2_ready,
   input  logic       en,
   output logic [3:0] dir,
   output logic       step,
   output logic       restart
);

   logic       ready_q;
   logic       armed;
   logic       evt;
   logic [7:0] held;
   logic [1:0] cur;
   logic       cur_valid;

   logic [7:0] held_nxt;
   logic [1:0] cur_nxt;
   logic       valid_nxt;
   logic       retrig;
   logic       clr;
   logic       restart_nxt;
   logic [2:0] lookup;
   logic [2:0] pos;
   logic [3:0] merged;

   // armed masks the first cycle after reset so a strobe held high across
   // reset is not mistaken for a fresh rising edge.
   assign evt = ps2_ready & ~ready_q & armed;

   always_comb begin
      held_nxt    = held;
      cur_nxt     = cur;
      valid_nxt   = cur_valid;
      retrig      = 1'b0;
      clr         = 1'b0;
      restart_nxt = 1'b0;
      lookup      = key_lookup(ps2_data[7:0], ps2_data[9]);
      pos         = {ps2_data[9], lookup[1:0]};
      merged      = 4'd0;
      if (evt) begin
         if (lookup[2]) begin
            if (!ps2_data[8]) begin
               if (!held[pos]) begin
                  held_nxt[pos] = 1'b1;
                  cur_nxt       = lookup[1:0];
                  valid_nxt     = 1'b1;
                  retrig        = 1'b1;
               end
            end else begin
               held_nxt[pos] = 1'b0;
               merged        = held_nxt[3:0] | held_nxt[7:4];
               // Only losing the last holder of the current direction moves cur.
               if (cur_valid && (lookup[1:0] == cur) && !merged[cur]) begin
                  if (merged != 4'd0) begin
                     cur_nxt = lowest_index(merged);
                     retrig  = 1'b1;
                  end else begin
                     valid_nxt = 1'b0;
                     clr       = 1'b1;
                  end
               end
            end
         end else if (ps2_data[7:0] == SC_R && !ps2_data[9] && !ps2_data[8]) begin
            restart_nxt = en;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q   <= 1'b0;
         armed     <= 1'b0;
         held      <= 8'd0;
         cur       <= 2'd0;
         cur_valid <= 1'b0;
         dir       <= STOP;
         restart   <= 1'b0;
      end else begin
         ready_q   <= ps2_ready;
         armed     <= 1'b1;
         held      <= held_nxt;
         cur       <= cur_nxt;
         cur_valid <= valid_nxt;
         dir       <= valid_nxt ? dir_of(cur_nxt) : STOP;
         restart   <= restart_nxt;
      end
   end

   ps2_dir_decoder_key_repeat_timer #(
      .DELAY_CYC  (DELAY_CYC),
      .REPEAT_CYC (REPEAT_CYC)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .restart_dly (retrig),
      .clear       (clr),
      .pulse_en    (en),
      .tick        (step)
   );

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Scoreboard bench for ps2_dir_decoder with short repeat timings (delay 8, repeat 4).
module tb_ps2_dir_decoder;
   import ps2_dir_decoder_pkg::*;

   localparam logic [9:0] W_MK     = {2'b00, 8'h1D};
   localparam logic [9:0] W_BRK    = {2'b01, 8'h1D};
   localparam logic [9:0] S_MK     = {2'b00, 8'h1B};
   localparam logic [9:0] S_BRK    = {2'b01, 8'h1B};
   localparam logic [9:0] EXT_S_MK = {2'b10, 8'h1B};
   localparam logic [9:0] D_MK     = {2'b00, 8'h23};
   localparam logic [9:0] D_BRK    = {2'b01, 8'h23};
   localparam logic [9:0] LEFT_MK  = {2'b10, 8'h6B};
   localparam logic [9:0] LEFT_BRK = {2'b11, 8'h6B};
   localparam logic [9:0] R_MK     = {2'b00, 8'h2D};
   localparam logic [9:0] R_BRK    = {2'b01, 8'h2D};

   typedef struct {
      int         cyc;
      logic [3:0] dir;
      logic       step;
      logic       restart;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [9:0] ps2_data;
   logic       ps2_ready;
   logic       en;
   logic [3:0] dir;
   logic       step;
   logic       restart;

   int         cyc;
   int         checks;
   int         failures;
   bit         mon_on;
   logic [3:0] hold_dir;
   exp_t       sb[$];
   int         k, e, f, g, h, p;

   ps2_dir_decoder #(
      .DELAY_CYC  (8),
      .REPEAT_CYC (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_data  (ps2_data),
      .ps2_ready (ps2_ready),
      .en        (en),
      .dir       (dir),
      .step      (step),
      .restart   (restart)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic push_exp(input int c, input logic [3:0] d, input logic s, input logic r);
      exp_t item;
      item.cyc     = c;
      item.dir     = d;
      item.step    = s;
      item.restart = r;
      sb.push_back(item);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one receiver word with a single-cycle ready pulse starting in cycle 'at'.
   task automatic applyStimulus(input logic [9:0] word, input int at);
      wait_until(at);
      ps2_data  = word;
      ps2_ready = 1'b1;
      @(posedge clk);
      #1;
      ps2_ready = 1'b0;
   endtask

   // Cycles without a scoreboard entry must hold the last direction and stay pulse-free.
   always @(negedge clk) begin
      if (mon_on) begin
         if (sb.size() > 0 && sb[0].cyc < cyc) begin
            checkOutput("sb_missed", sb[0].cyc, cyc);
            void'(sb.pop_front());
         end
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_t item;
            item = sb.pop_front();
            checkOutput("dir", {28'd0, dir}, {28'd0, item.dir});
            checkOutput("step", {31'd0, step}, {31'd0, item.step});
            checkOutput("restart", {31'd0, restart}, {31'd0, item.restart});
            hold_dir = item.dir;
         end else begin
            checkOutput("dir_hold", {28'd0, dir}, {28'd0, hold_dir});
            checkOutput("no_step", {31'd0, step}, 32'd0);
            checkOutput("no_restart", {31'd0, restart}, 32'd0);
         end
      end
   end

   initial begin
      checks    = 0;
      failures  = 0;
      mon_on    = 1'b0;
      hold_dir  = STOP;
      rst       = 1'b1;
      en        = 1'b1;
      ps2_ready = 1'b0;
      ps2_data  = 10'd0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_dir", {28'd0, dir}, 32'd0);
      checkOutput("reset_step", {31'd0, step}, 32'd0);
      checkOutput("reset_restart", {31'd0, restart}, 32'd0);
      rst    = 1'b0;
      mon_on = 1'b1;

      // W press: immediate step, first repeat after 8, then every 4.
      k = cyc + 3;
      push_exp(k + 1,  PA_UP, 1'b1, 1'b0);
      push_exp(k + 9,  PA_UP, 1'b1, 1'b0);
      push_exp(k + 13, PA_UP, 1'b1, 1'b0);
      push_exp(k + 17, PA_UP, 1'b1, 1'b0);
      applyStimulus(W_MK, k);

      // W release lands in the cycle a repeat would fire: the release wins.
      push_exp(k + 21, STOP, 1'b0, 1'b0);
      applyStimulus(W_BRK, k + 20);
      wait_until(k + 40);
      checkOutput("fsm_idle", {30'd0, dut.u_timer.state}, {30'd0, IDLE});

      // W held, Left arrow pressed then released: fallback to W restarts delay.
      e = k + 42;
      push_exp(e + 1,  PA_UP,   1'b1, 1'b0);
      push_exp(e + 4,  PA_LEFT, 1'b1, 1'b0);
      push_exp(e + 7,  PA_UP,   1'b1, 1'b0);
      push_exp(e + 15, PA_UP,   1'b1, 1'b0);
      push_exp(e + 18, STOP,    1'b0, 1'b0);
      applyStimulus(W_MK, e);
      applyStimulus(LEFT_MK, e + 3);
      applyStimulus(LEFT_BRK, e + 6);
      applyStimulus(W_BRK, e + 17);

      // Typematic re-sends of a held key leave the cadence untouched.
      f = e + 20;
      push_exp(f + 1,  PA_UP, 1'b1, 1'b0);
      push_exp(f + 9,  PA_UP, 1'b1, 1'b0);
      push_exp(f + 13, PA_UP, 1'b1, 1'b0);
      push_exp(f + 17, PA_UP, 1'b1, 1'b0);
      push_exp(f + 19, STOP,  1'b0, 1'b0);
      applyStimulus(W_MK, f);
      for (int i = 1; i <= 5; i++) applyStimulus(W_MK, f + 2 * i);
      applyStimulus(W_BRK, f + 18);

      // Restart pulse, its suppression by en, R break and extended S ignored.
      g = f + 22;
      push_exp(g + 1, STOP, 1'b0, 1'b1);
      applyStimulus(R_MK, g);
      wait_until(g + 2);
      en = 1'b0;
      applyStimulus(R_MK, g + 3);
      en = 1'b1;
      applyStimulus(R_BRK, g + 5);
      applyStimulus(EXT_S_MK, g + 7);
      wait_until(g + 8);
      en = 1'b0;
      push_exp(g + 10, PA_DN, 1'b0, 1'b0);
      applyStimulus(S_MK, g + 9);
      wait_until(g + 12);
      en = 1'b1;
      push_exp(g + 18, PA_DN, 1'b1, 1'b0);
      push_exp(g + 20, STOP,  1'b0, 1'b0);
      applyStimulus(S_BRK, g + 19);

      // Reset mid-countdown while D is held and ready stays high.
      h = g + 22;
      push_exp(h + 1, PA_RIGHT, 1'b1, 1'b0);
      applyStimulus(D_MK, h);
      wait_until(h + 5);
      mon_on = 1'b0;
      checkOutput("cnt_before_rst", dut.u_timer.cnt, 32'd3);
      ps2_data  = D_MK;
      ps2_ready = 1'b1;
      rst       = 1'b1;
      #1;
      checkOutput("rst_dir", {28'd0, dir}, 32'd0);
      checkOutput("rst_step", {31'd0, step}, 32'd0);
      checkOutput("rst_restart", {31'd0, restart}, 32'd0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      hold_dir = STOP;
      mon_on   = 1'b1;
      wait_until(h + 30);
      ps2_ready = 1'b0;

      // Re-pressing D after reset steps again.
      p = h + 32;
      push_exp(p + 1, PA_RIGHT, 1'b1, 1'b0);
      push_exp(p + 3, STOP,     1'b0, 1'b0);
      applyStimulus(D_MK, p);
      applyStimulus(D_BRK, p + 2);
      wait_until(p + 10);

      checkOutput("sb_empty", sb.size(), 32'd0);
      mon_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
